// File: rtl/puc_pkg.sv
// Shared types and default sizes for the program sequencer.
package puc_pkg;

  localparam int DEFAULT_COUNTER_WIDTH = 8;
  localparam int DEFAULT_WIDTH         = 16;
  localparam int DEFAULT_STACK_DEPTH   = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/call_stack.sv
// Return-address LIFO. The top entry is visible combinationally on pop_data
// so a return can redirect the sequencer in the same cycle it pops.
module call_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  // Pointer counts occupied entries, so it needs to represent 0..DEPTH.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    ptr_reg;
  logic [WIDTH-1:0] entries [DEPTH];
  logic [AW-1:0]    top_idx;

  assign full     = (ptr_reg == CW'(DEPTH));
  assign empty    = (ptr_reg == '0);
  assign top_idx  = AW'(ptr_reg - CW'(1));
  assign pop_data = entries[top_idx];

  // Occupancy pointer; a simultaneous push and pop is never requested by the sequencer.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (push && !full) begin
      ptr_reg <= ptr_reg + CW'(1);
    end else if (pop && !empty) begin
      ptr_reg <= ptr_reg - CW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Each slot captures the pushed address when the pointer lands on it.
      always_ff @(posedge clock) begin
        if (push && !full && (ptr_reg == CW'(gi))) begin
          entries[gi] <= push_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/program_sequencer.sv
// Program counter / fetch sequencer with RUN, HALT and FAULT states.
// Optional return stack enabled by defining PUC_CALL_STACK_EN; without it
// call and ret are ignored and the sequencer can never fault.
module program_sequencer
  import puc_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int STACK_DEPTH   = DEFAULT_STACK_DEPTH,
  parameter logic [COUNTER_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         instruction,
  input  logic                     stall,
  input  logic                     jump,
  input  logic                     branch,
  input  logic                     condition,
  input  logic                     call,
  input  logic                     ret,
  input  logic [COUNTER_WIDTH-1:0] target,
  input  logic                     halt,
  input  logic                     resume,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic [WIDTH-1:0]         instruction_q,
  output logic                     valid,
  output logic                     halted,
  output logic                     fault
);

  seq_state_t               state_reg, state_next;
  logic [COUNTER_WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0]         iq_reg, iq_next;
  logic                     valid_reg, valid_next;

  logic [COUNTER_WIDTH-1:0] count_inc;
  logic                     call_en, ret_en;
  logic                     push, pop;
  logic                     stack_full, stack_empty;
  logic [COUNTER_WIDTH-1:0] pop_data;

  assign count_inc = count_reg + COUNTER_WIDTH'(1);

`ifdef PUC_CALL_STACK_EN
  assign call_en = call;
  assign ret_en  = ret;

  call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (COUNTER_WIDTH)
  ) u_call_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (count_inc),
    .pop_data  (pop_data),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  assign fault = (state_reg == FAULT);
`else
  logic unused_ok;
  assign call_en     = 1'b0;
  assign ret_en      = 1'b0;
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign pop_data    = '0;
  assign unused_ok   = &{1'b0, call, ret, push, pop};
  assign fault       = 1'b0;
`endif

  // Next-state and fetch control; RUN priority is halt > stall > ret > call > jump > taken branch.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    iq_next    = iq_reg;
    valid_next = valid_reg;
    push       = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      RUN: begin
        if (halt) begin
          state_next = HALT;
          valid_next = 1'b0;
        end else if (stall) begin
          // Everything holds, redirects are dropped.
        end else if (ret_en) begin
          valid_next = 1'b0;
          if (stack_empty) begin
            state_next = FAULT;
          end else begin
            pop        = 1'b1;
            count_next = pop_data;
            iq_next    = instruction;
          end
        end else if (call_en) begin
          valid_next = 1'b0;
          if (stack_full) begin
            state_next = FAULT;
          end else begin
            push       = 1'b1;
            count_next = target;
            iq_next    = instruction;
          end
        end else if (jump || (branch && condition)) begin
          count_next = target;
          iq_next    = instruction;
          valid_next = 1'b0;
        end else begin
          count_next = count_inc;
          iq_next    = instruction;
          valid_next = 1'b1;
        end
      end
      HALT: begin
        valid_next = 1'b0;
        if (resume && !halt) begin
          state_next = RUN;
        end
      end
      FAULT: begin
        valid_next = 1'b0;
      end
      default: begin
        state_next = RUN;
        valid_next = 1'b0;
      end
    endcase
  end

  // State, program counter and fetch register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= RUN;
      count_reg <= RESET_VECTOR;
      iq_reg    <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      iq_reg    <= iq_next;
      valid_reg <= valid_next;
    end
  end

  assign count         = count_reg;
  assign instruction_q = iq_reg;
  assign valid         = valid_reg;
  assign halted        = (state_reg == HALT);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed, table-driven bench for program_sequencer. Instruction memory is
// modelled as mem[a] = 0x1000 + a. Stack sequences run only when
// PUC_CALL_STACK_EN is defined; otherwise call/ret are checked to be ignored.
module tb_program_sequencer;

  localparam logic [7:0] C_STALL = 8'h01;
  localparam logic [7:0] C_JUMP  = 8'h02;
  localparam logic [7:0] C_BR    = 8'h04;
  localparam logic [7:0] C_COND  = 8'h08;
  localparam logic [7:0] C_CALL  = 8'h10;
  localparam logic [7:0] C_RET   = 8'h20;
  localparam logic [7:0] C_HALT  = 8'h40;
  localparam logic [7:0] C_RES   = 8'h80;
  localparam int N_VEC = 25;

  typedef struct {
    logic [7:0]  ctl;
    logic [7:0]  target;
    logic [7:0]  e_count;
    logic [15:0] e_iq;
    logic        e_valid;
    logic        e_halted;
    logic        e_fault;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        stall, jump, branch, condition, call, ret, halt, resume;
  logic [7:0]  target;
  logic [7:0]  count;
  logic [15:0] instruction_q;
  logic        valid, halted, fault;

  int checks = 0;
  int errors = 0;
  vec_t tbl [N_VEC];

  program_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .instruction   (instruction),
    .stall         (stall),
    .jump          (jump),
    .branch        (branch),
    .condition     (condition),
    .call          (call),
    .ret           (ret),
    .target        (target),
    .halt          (halt),
    .resume        (resume),
    .count         (count),
    .instruction_q (instruction_q),
    .valid         (valid),
    .halted        (halted),
    .fault         (fault)
  );

  always #5 clock = ~clock;

  assign instruction = 16'h1000 + {8'h00, count};

  function automatic vec_t mk(input logic [7:0] ctl, input logic [7:0] tgt,
                              input logic [7:0] ec, input logic [15:0] eiq,
                              input logic ev, input logic eh, input logic ef);
    vec_t v;
    v.ctl = ctl; v.target = tgt; v.e_count = ec; v.e_iq = eiq;
    v.e_valid = ev; v.e_halted = eh; v.e_fault = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ctl(input logic [7:0] ctl, input logic [7:0] tgt);
    {resume, halt, ret, call, condition, branch, jump, stall} = ctl;
    target = tgt;
  endtask

  // Apply one vector for one clock, then compare every output.
  task automatic run_vec(input vec_t v, input string tag);
    set_ctl(v.ctl, v.target);
    @(posedge clock);
    #1;
    $display("%s ctl=%02h tgt=%02h -> count=%02h iq=%04h valid=%0b halted=%0b fault=%0b",
             tag, v.ctl, v.target, count, instruction_q, valid, halted, fault);
    check({tag, " count"},  32'(count),         32'(v.e_count));
    check({tag, " iq"},     32'(instruction_q), 32'(v.e_iq));
    check({tag, " valid"},  32'(valid),         32'(v.e_valid));
    check({tag, " halted"}, 32'(halted),        32'(v.e_halted));
    check({tag, " fault"},  32'(fault),         32'(v.e_fault));
  endtask

  // Reset for two clocks with the given control inputs still driven.
  task automatic do_reset(input logic [7:0] ctl, input string tag);
    set_ctl(ctl, 8'h77);
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    $display("%s reset -> count=%02h iq=%04h valid=%0b halted=%0b fault=%0b",
             tag, count, instruction_q, valid, halted, fault);
    check({tag, " rst count"},  32'(count),         32'h0);
    check({tag, " rst iq"},     32'(instruction_q), 32'h0);
    check({tag, " rst valid"},  32'(valid),         32'h0);
    check({tag, " rst halted"}, 32'(halted),        32'h0);
    check({tag, " rst fault"},  32'(fault),         32'h0);
    reset = 1'b0;
    set_ctl(8'h00, 8'h00);
  endtask

  initial begin
    set_ctl(8'h00, 8'h00);
    reset = 1'b1;

    // Free run, redirects, stall, halt/resume and wrap-around.
    tbl[0]  = mk(8'h00,           8'h00, 8'h01, 16'h1000, 1, 0, 0);
    tbl[1]  = mk(8'h00,           8'h00, 8'h02, 16'h1001, 1, 0, 0);
    tbl[2]  = mk(8'h00,           8'h00, 8'h03, 16'h1002, 1, 0, 0);
    tbl[3]  = mk(8'h00,           8'h00, 8'h04, 16'h1003, 1, 0, 0);
    tbl[4]  = mk(8'h00,           8'h00, 8'h05, 16'h1004, 1, 0, 0);
    tbl[5]  = mk(C_JUMP,          8'h40, 8'h40, 16'h1005, 0, 0, 0);
    tbl[6]  = mk(8'h00,           8'h00, 8'h41, 16'h1040, 1, 0, 0);
    tbl[7]  = mk(C_BR,            8'h10, 8'h42, 16'h1041, 1, 0, 0);
    tbl[8]  = mk(C_BR | C_COND,   8'h10, 8'h10, 16'h1042, 0, 0, 0);
    tbl[9]  = mk(8'h00,           8'h00, 8'h11, 16'h1010, 1, 0, 0);
    tbl[10] = mk(C_STALL | C_JUMP, 8'h80, 8'h11, 16'h1010, 1, 0, 0);
    tbl[11] = mk(C_STALL | C_JUMP, 8'h80, 8'h11, 16'h1010, 1, 0, 0);
    tbl[12] = mk(C_STALL | C_JUMP, 8'h80, 8'h11, 16'h1010, 1, 0, 0);
    tbl[13] = mk(C_HALT | C_JUMP, 8'h80, 8'h11, 16'h1010, 0, 1, 0);
    tbl[14] = mk(C_JUMP,          8'h80, 8'h11, 16'h1010, 0, 1, 0);
    tbl[15] = mk(C_RES,           8'h00, 8'h11, 16'h1010, 0, 0, 0);
    tbl[16] = mk(8'h00,           8'h00, 8'h12, 16'h1011, 1, 0, 0);
    tbl[17] = mk(C_HALT | C_RES,  8'h00, 8'h12, 16'h1011, 0, 1, 0);
    tbl[18] = mk(C_HALT | C_RES,  8'h00, 8'h12, 16'h1011, 0, 1, 0);
    tbl[19] = mk(C_RES,           8'h00, 8'h12, 16'h1011, 0, 0, 0);
    tbl[20] = mk(8'h00,           8'h00, 8'h13, 16'h1012, 1, 0, 0);
    tbl[21] = mk(C_JUMP,          8'hFE, 8'hFE, 16'h1013, 0, 0, 0);
    tbl[22] = mk(8'h00,           8'h00, 8'hFF, 16'h10FE, 1, 0, 0);
    tbl[23] = mk(8'h00,           8'h00, 8'h00, 16'h10FF, 1, 0, 0);
    tbl[24] = mk(8'h00,           8'h00, 8'h01, 16'h1000, 1, 0, 0);

    do_reset(8'h00, "init");
    for (int i = 0; i < N_VEC; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset must win over an active halt request and over HALT state.
    run_vec(mk(C_HALT, 8'h00, 8'h01, 16'h1000, 0, 1, 0), "hrst0");
    do_reset(C_HALT | C_STALL, "hrst");
    run_vec(mk(8'h00, 8'h00, 8'h01, 16'h1000, 1, 0, 0), "hrst1");

`ifdef PUC_CALL_STACK_EN
    // Four nested calls fill the stack; returns unwind in LIFO order.
    do_reset(8'h00, "stk");
    run_vec(mk(C_CALL, 8'h10, 8'h10, 16'h1000, 0, 0, 0), "stk0");
    run_vec(mk(C_CALL, 8'h20, 8'h20, 16'h1010, 0, 0, 0), "stk1");
    run_vec(mk(C_CALL, 8'h30, 8'h30, 16'h1020, 0, 0, 0), "stk2");
    run_vec(mk(C_CALL, 8'h40, 8'h40, 16'h1030, 0, 0, 0), "stk3");
    run_vec(mk(C_RET | C_JUMP, 8'h99, 8'h31, 16'h1040, 0, 0, 0), "stk4");
    run_vec(mk(8'h00,  8'h00, 8'h32, 16'h1031, 1, 0, 0), "stk5");
    run_vec(mk(C_CALL, 8'h50, 8'h50, 16'h1032, 0, 0, 0), "stk6");
    run_vec(mk(C_RET,  8'h00, 8'h33, 16'h1050, 0, 0, 0), "stk7");
    run_vec(mk(C_RET,  8'h00, 8'h21, 16'h1033, 0, 0, 0), "stk8");
    run_vec(mk(C_RET,  8'h00, 8'h11, 16'h1021, 0, 0, 0), "stk9");
    run_vec(mk(C_RET,  8'h00, 8'h01, 16'h1011, 0, 0, 0), "stk10");
    run_vec(mk(C_RET,  8'h00, 8'h01, 16'h1011, 0, 0, 1), "stk11");
    run_vec(mk(C_JUMP | C_RES, 8'h44, 8'h01, 16'h1011, 0, 0, 1), "stk12");

    // Fifth call overflows.
    do_reset(8'h00, "ovf");
    run_vec(mk(C_CALL, 8'h10, 8'h10, 16'h1000, 0, 0, 0), "ovf0");
    run_vec(mk(C_CALL, 8'h20, 8'h20, 16'h1010, 0, 0, 0), "ovf1");
    run_vec(mk(C_CALL, 8'h30, 8'h30, 16'h1020, 0, 0, 0), "ovf2");
    run_vec(mk(C_CALL, 8'h40, 8'h40, 16'h1030, 0, 0, 0), "ovf3");
    run_vec(mk(C_CALL, 8'h50, 8'h40, 16'h1030, 0, 0, 1), "ovf4");
    run_vec(mk(8'h00,  8'h00, 8'h40, 16'h1030, 0, 0, 1), "ovf5");

    // Return on an empty stack straight after reset.
    do_reset(8'h00, "udf");
    run_vec(mk(C_RET,  8'h00, 8'h00, 16'h0000, 0, 0, 1), "udf0");

    // Call from 0xFF pushes the wrapped return address 0x00.
    do_reset(8'h00, "wrp");
    run_vec(mk(C_JUMP, 8'hFF, 8'hFF, 16'h1000, 0, 0, 0), "wrp0");
    run_vec(mk(C_CALL, 8'h05, 8'h05, 16'h10FF, 0, 0, 0), "wrp1");
    run_vec(mk(C_RET,  8'h00, 8'h00, 16'h1005, 0, 0, 0), "wrp2");
    run_vec(mk(8'h00,  8'h00, 8'h01, 16'h1000, 1, 0, 0), "wrp3");
`else
    // Without the stack, call and ret are plain no-ops.
    do_reset(8'h00, "nst");
    run_vec(mk(8'h00,  8'h00, 8'h01, 16'h1000, 1, 0, 0), "nst0");
    run_vec(mk(8'h00,  8'h00, 8'h02, 16'h1001, 1, 0, 0), "nst1");
    run_vec(mk(8'h00,  8'h00, 8'h03, 16'h1002, 1, 0, 0), "nst2");
    run_vec(mk(C_CALL, 8'h20, 8'h04, 16'h1003, 1, 0, 0), "nst3");
    run_vec(mk(C_RET,  8'h00, 8'h05, 16'h1004, 1, 0, 0), "nst4");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter COUNTER_WIDTH, default 8, program-counter and address width.
REQ-002 Parameter WIDTH, default 16, instruction width.
REQ-003 Parameter STACK_DEPTH, default 4, return-stack entries (>=1).
REQ-004 Parameter RESET_VECTOR, default 0, count value after reset.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 instruction  input  WIDTH  combinational instruction-memory data for address count.
REQ-008 stall  input  1  hold count and instruction_q this cycle.
REQ-009 jump  input  1  unconditional redirect to target.
REQ-010 branch  input  1  conditional redirect to target when condition=1.
REQ-011 condition  input  1  branch qualifier.
REQ-012 call  input  1  push return address, redirect to target.
REQ-013 ret  input  1  pop return address into count.
REQ-014 target  input  COUNTER_WIDTH  redirect address.
REQ-015 halt  input  1  request HALT state.
REQ-016 resume  input  1  leave HALT state.
REQ-017 count  output  COUNTER_WIDTH  current fetch address (registered).
REQ-018 instruction_q  output  WIDTH  registered fetched instruction.
REQ-019 valid  output  1  instruction_q holds a live, non-squashed instruction.
REQ-020 halted  output  1  state is HALT.
REQ-021 fault  output  1  state is FAULT (sticky until reset).

Function
REQ-022 FSM states RUN, HALT, FAULT; RUN->HALT on halt; HALT->RUN on resume with halt=0; RUN->FAULT on stack overflow/underflow; FAULT exits only via reset.
REQ-023 Count-update priority in RUN: halt > stall > ret > call > jump > (branch & condition) > count+1.
REQ-024 Increment wraps: 2^COUNTER_WIDTH-1 -> 0; call pushes count+1 with same wrap.
REQ-025 Fetch latency one cycle: count=A at edge N gives instruction_q=mem[A] after edge N+1.
REQ-026 Non-stalled RUN cycle without redirect: instruction_q<=instruction, valid<=1.
REQ-027 Redirect cycle (taken jump/branch/call/ret): instruction_q loaded but valid<=0 (squash); branch with condition=0 is not a redirect.
REQ-028 Stall in RUN: count, instruction_q, valid unchanged; all redirect inputs ignored.
REQ-029 HALT and FAULT: count and instruction_q frozen, valid<=0, all control inputs except reset/resume ignored.
REQ-030 Call with stack full: no push, count unchanged, valid<=0, enter FAULT next edge.
REQ-031 Ret with stack empty: no pop, count unchanged, valid<=0, enter FAULT next edge.
REQ-032 Halt asserted together with any redirect: halt wins, redirect discarded.

Reset
REQ-033 Reset overrides everything, including mid-stall, HALT and FAULT.
REQ-034 After reset: count=RESET_VECTOR, instruction_q=0, valid=0, halted=0, fault=0, state RUN, stack empty.

Configuration
REQ-035 Macro PUC_CALL_STACK_EN defined: call/ret/stack behave per REQ-012/013/030/031.
REQ-036 Macro undefined: no stack storage; call and ret ignored (treated as 0); FAULT unreachable, fault tied 0.

Structure
REQ-037 Package puc_pkg holds seq_state_t enum (RUN, HALT, FAULT) and default constants for COUNTER_WIDTH, WIDTH, STACK_DEPTH.
REQ-038 Return stack is sub-module call_stack (LIFO, push/pop/full/empty, synchronous reset), instantiated only under PUC_CALL_STACK_EN.

Verification
REQ-039 Reset, then 3 free-run cycles, mem[i]=0x1000+i -> count 0,1,2,3; instruction_q 0x1000,0x1001,0x1002 with valid=1 from cycle 2.
REQ-040 count=0xFF, no control -> count=0x00 next edge; call at 0xFF pushes 0x00.
REQ-041 jump=1 target=0x40 at count=5 -> count=0x40, valid=0 one cycle, then mem[0x40] valid; branch condition=0 -> count=6.
REQ-042 STACK_DEPTH=4: 4 calls succeed, 5th -> fault=1, count frozen; ret on empty stack after reset -> fault=1; reset clears both.
REQ-043 stall=1 with jump=1 for 3 cycles -> count, instruction_q constant; halt+jump same cycle -> halted=1, count unchanged; resume -> RUN, count+1 next edge.
REQ-044 Build without PUC_CALL_STACK_EN: call=1 target=0x20 at count=3 -> count=4, fault stays 0.
